pixel_feeder_stream: RTL and testbench

PIXEL_FEEDER_STREAM -- requirements
Module: pixel_feeder_stream

---
 rtl/pixel_feeder_pkg.sv | 17 +
 rtl/pixel_feeder_stream_if.sv | 30 +++
 rtl/pixel_feeder_stream_sync_fifo.sv | 58 +++++
 rtl/pixel_feeder_stream.sv | 135 +++++++++++++
 tb/tb_pixel_feeder_stream.sv | 336 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pixel_feeder_pkg.sv
// Shared types and default geometry for the pixel feeder.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pixel_feeder_pkg;

   localparam int DEF_PIX_W      = 8;
   localparam int DEF_FIFO_DEPTH = 16;
   localparam int DEF_IMG_W      = 64;
   localparam int DEF_IMG_H      = 64;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/pixel_feeder_stream_if.sv
// Pixel bus: CPU write side in, convolution-core stream out.
// Latency: n/a (wires only).
// Backpressure: px_ready toward the CPU, ready_out from the core.
interface pixel_feeder_stream_if
   import pixel_feeder_pkg::*;
#(
   parameter int PIX_W = DEF_PIX_W
);
   logic             px_valid;
   logic [PIX_W-1:0] px_in;
   logic             px_ready;
   logic             valid_out;
   logic [PIX_W-1:0] px_out;
   logic             ready_out;
   logic             sof;
   logic             eol;
   logic             eof;

   // Environment side: CPU writer plus convolution core.
   modport master (
      output px_valid, px_in, ready_out,
      input  px_ready, valid_out, px_out, sof, eol, eof
   );

   // Feeder side.
   modport slave (
      input  px_valid, px_in, ready_out,
      output px_ready, valid_out, px_out, sof, eol, eof
   );
endinterface

// File: rtl/pixel_feeder_stream_sync_fifo.sv
// Single-clock FIFO with synchronous flush and occupancy count.
// Latency: written word visible on rd_data the edge after the write.
// Backpressure: writes dropped when full, reads ignored when empty.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       wr_en,
   input  logic [WIDTH-1:0]           wr_data,
   input  logic                       rd_en,
   output logic [WIDTH-1:0]           rd_data,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] level
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [LW-1:0]    count;
   logic             do_wr;
   logic             do_rd;

   assign do_wr   = wr_en && !full;
   assign do_rd   = rd_en && !empty;
   assign full    = (count == LW'(DEPTH));
   assign empty   = (count == '0);
   assign level   = count;
   assign rd_data = mem[rd_ptr];

   // Pointer and occupancy bookkeeping; flush empties without touching storage.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + AW'(1);
         if (do_rd) rd_ptr <= rd_ptr + AW'(1);
         if (do_wr && !do_rd)      count <= count + LW'(1);
         else if (!do_wr && do_rd) count <= count - LW'(1);
      end
   end

   // Storage array, no reset needed since reads are gated by count.
   always_ff @(posedge clk) begin
      if (do_wr && !flush) mem[wr_ptr] <= wr_data;
   end
endmodule

// File: rtl/pixel_feeder_stream.sv
// Buffers CPU pixels and streams one frame per start with sof/eol/eof markers; optional ovf flag under PIXEL_FEEDER_OVF_EN.
// Latency: pixel written into an empty buffer in RUN is presented on valid_out one edge later.
// Backpressure: px_ready drops when the buffer is full; output register holds while ready_out is low.
module pixel_feeder_stream
   import pixel_feeder_pkg::*;
#(
   parameter int PIX_W      = DEF_PIX_W,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
   parameter int IMG_W      = DEF_IMG_W,
   parameter int IMG_H      = DEF_IMG_H
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            start,
   input  logic                            abort,
   pixel_feeder_stream_if.slave            bus,
   output logic                            frame_done,
   output logic [$clog2(FIFO_DEPTH+1)-1:0] level
`ifdef PIXEL_FEEDER_OVF_EN
   ,
   output logic                            ovf,
   input  logic                            ovf_clr
`endif
);
   localparam int COL_W = $clog2(IMG_W);
   localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;

   state_t           state;
   state_t           state_nxt;
   logic [COL_W-1:0] col;
   logic [ROW_W-1:0] row;
   logic [PIX_W-1:0] fifo_dat;
   logic             fifo_full;
   logic             fifo_empty;
   logic             wr_en;
   logic             load;
   logic             hs;
   logic             at_eol;
   logic             at_eof;
   logic             out_vld;
   logic [PIX_W-1:0] out_dat;

   assign hs     = out_vld && bus.ready_out;
   assign at_eol = (col == COL_W'(IMG_W-1));
   assign at_eof = at_eol && (row == ROW_W'(IMG_H-1));
   assign wr_en  = bus.px_valid && !fifo_full && !abort;
   // The pixel after eof belongs to the next frame, so it stays buffered.
   assign load   = (state == ST_RUN) && !fifo_empty && !abort &&
                   (!out_vld || (bus.ready_out && !at_eof));

   sync_fifo #(
      .WIDTH (PIX_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .flush   (abort),
      .wr_en   (wr_en),
      .wr_data (bus.px_in),
      .rd_en   (load),
      .rd_data (fifo_dat),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .level   (level)
   );

   // Frame state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   // Frame sequencing; abort overrides everything including start.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (start)       state_nxt = ST_RUN;
         ST_RUN:  if (hs && at_eof) state_nxt = ST_DONE;
         ST_DONE:                   state_nxt = ST_IDLE;
         default:                   state_nxt = ST_IDLE;
      endcase
      if (abort) state_nxt = ST_IDLE;
   end

   // Output register: refills on the same edge it drains to keep full rate.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_vld <= 1'b0;
         out_dat <= '0;
      end else if (abort) begin
         out_vld <= 1'b0;
      end else if (load) begin
         out_vld <= 1'b1;
         out_dat <= fifo_dat;
      end else if (hs) begin
         out_vld <= 1'b0;
      end
   end

   // Position of the presented pixel; advances only when the core takes it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col <= '0;
         row <= '0;
      end else if (abort) begin
         col <= '0;
         row <= '0;
      end else if (hs) begin
         if (at_eol) begin
            col <= '0;
            row <= at_eof ? '0 : row + ROW_W'(1);
         end else begin
            col <= col + COL_W'(1);
         end
      end
   end

`ifdef PIXEL_FEEDER_OVF_EN
   // Sticky drop indicator; a new drop wins over a same-cycle clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                            ovf <= 1'b0;
      else if (abort)                     ovf <= 1'b0;
      else if (bus.px_valid && fifo_full) ovf <= 1'b1;
      else if (ovf_clr)                   ovf <= 1'b0;
   end
`endif

   assign bus.px_ready  = !fifo_full;
   assign bus.valid_out = out_vld;
   assign bus.px_out    = out_dat;
   assign bus.sof       = out_vld && (col == '0) && (row == '0);
   assign bus.eol       = out_vld && at_eol;
   assign bus.eof       = out_vld && at_eof;
   assign frame_done    = (state == ST_DONE);
endmodule

// File: tb/tb_pixel_feeder_stream.sv
// Scoreboarded bench for pixel_feeder_stream with a small image and buffer.
// Latency: n/a.
// Backpressure: ready_out is randomised and held low in directed stalls.
module tb_pixel_feeder_stream;
   localparam int PIX_W = 8;
   localparam int DEPTH = 4;
   localparam int IMG_W = 4;
   localparam int IMG_H = 2;
   localparam int FRAME = IMG_W * IMG_H;
   localparam int LVL_W = $clog2(DEPTH+1);

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic             abort;
   logic             frame_done;
   logic [LVL_W-1:0] level;
`ifdef PIXEL_FEEDER_OVF_EN
   logic             ovf;
   logic             ovf_clr;
`endif

   pixel_feeder_stream_if #(.PIX_W(PIX_W)) bus();

   pixel_feeder_stream #(
      .PIX_W      (PIX_W),
      .FIFO_DEPTH (DEPTH),
      .IMG_W      (IMG_W),
      .IMG_H      (IMG_H)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .abort      (abort),
      .bus        (bus),
      .frame_done (frame_done),
      .level      (level)
`ifdef PIXEL_FEEDER_OVF_EN
      ,
      .ovf        (ovf),
      .ovf_clr    (ovf_clr)
`endif
   );

   always #5 clk = ~clk;

   int               n_chk = 0;
   int               n_fail = 0;
   logic [PIX_W-1:0] exp_q[$];
   int               pos = 0;
   bit               in_frame = 1'b0;
   bit               fd_due = 1'b0;
   bit               held = 1'b0;
   logic [31:0]      held_val;
   int               frames_done = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Output monitor: pops the scoreboard on every core handshake.
   always @(negedge clk) begin
      if (rst) begin
         held   = 1'b0;
         fd_due = 1'b0;
      end else begin
         check("frame_done", 32'(frame_done), 32'(fd_due));
         fd_due = 1'b0;
         if (!in_frame) check("valid_outside_frame", 32'(bus.valid_out), 32'd0);
         if (held) begin
            check("stall_valid", 32'(bus.valid_out), 32'd1);
            check("stall_hold", 32'({bus.px_out, bus.sof, bus.eol, bus.eof}), held_val);
         end
         held = 1'b0;
         if (bus.valid_out && !abort) begin
            if (bus.ready_out) begin
               if (exp_q.size() == 0) begin
                  n_chk++;
                  n_fail++;
                  $display("FAIL px_unexpected: got %0h with empty scoreboard at %0t", bus.px_out, $time);
               end else begin
                  logic [PIX_W-1:0] e;
                  e = exp_q.pop_front();
                  check("px_out", 32'(bus.px_out), 32'(e));
                  check("markers", 32'({bus.sof, bus.eol, bus.eof}),
                        32'({pos == 0, (pos % IMG_W) == IMG_W-1, pos == FRAME-1}));
                  pos++;
                  if (pos == FRAME) begin
                     pos = 0;
                     in_frame = 1'b0;
                     fd_due = 1'b1;
                     frames_done++;
                  end
               end
            end else begin
               held = 1'b1;
               held_val = 32'({bus.px_out, bus.sof, bus.eol, bus.eof});
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue a write and record it as expected output if the buffer has room.
   task automatic write_px(input logic [PIX_W-1:0] d);
      bus.px_valid = 1'b1;
      bus.px_in    = d;
      if (exp_q.size() < DEPTH) exp_q.push_back(d);
   endtask

   task automatic push_when_room(input logic [PIX_W-1:0] d);
      int c = 0;
      bus.px_valid = 1'b0;
      while (exp_q.size() >= DEPTH && c < 100) begin
         tick();
         c++;
      end
      check("room_wait", 32'(exp_q.size() < DEPTH), 32'd1);
      write_px(d);
      tick();
      bus.px_valid = 1'b0;
   endtask

   task automatic start_frame();
      start    = 1'b1;
      in_frame = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_frame_end(input int budget);
      int c = 0;
      bus.px_valid = 1'b0;
      while (in_frame && c < budget) begin
         tick();
         c++;
      end
      check("frame_timeout", 32'(in_frame), 32'd0);
      tick();
      tick();
   endtask

   // Random traffic until the frame completes; stray starts must be ignored.
   task automatic run_frame(input int budget);
      int c = 0;
      while (in_frame && c < budget) begin
         bus.px_valid  = 1'b0;
         if (exp_q.size() < DEPTH && ($urandom % 2) == 0) write_px(PIX_W'($urandom));
         bus.ready_out = (($urandom % 4) != 0);
         start         = (($urandom % 8) == 0);
         tick();
         c++;
      end
      start        = 1'b0;
      bus.px_valid = 1'b0;
      check("frame_timeout", 32'(in_frame), 32'd0);
      tick();
      tick();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      int written;
      int c;
      rst           = 1'b1;
      start         = 1'b0;
      abort         = 1'b0;
      bus.px_valid  = 1'b0;
      bus.px_in     = '0;
      bus.ready_out = 1'b0;
`ifdef PIXEL_FEEDER_OVF_EN
      ovf_clr       = 1'b0;
`endif
      repeat (2) @(posedge clk);
      #1;
      check("rst_level", 32'(level), 32'd0);
      check("rst_px_ready", 32'(bus.px_ready), 32'd1);
      check("rst_valid", 32'(bus.valid_out), 32'd0);
      check("rst_markers", 32'({bus.sof, bus.eol, bus.eof}), 32'd0);
      check("rst_frame_done", 32'(frame_done), 32'd0);
      check("rst_px_out", 32'(bus.px_out), 32'd0);
`ifdef PIXEL_FEEDER_OVF_EN
      check("rst_ovf", 32'(ovf), 32'd0);
`endif
      rst = 1'b0;
      tick();

      // Overflow while idle: four stored, fifth dropped.
      for (int i = 1; i <= 5; i++) begin
         write_px(PIX_W'(i));
         tick();
         check("ovf_px_ready", 32'(bus.px_ready), 32'(i < DEPTH));
         check("ovf_level", 32'(level), 32'((i < DEPTH) ? i : DEPTH));
      end
      bus.px_valid = 1'b0;
`ifdef PIXEL_FEEDER_OVF_EN
      tick();
      check("ovf_set", 32'(ovf), 32'd1);
      bus.px_valid = 1'b1;
      bus.px_in    = 8'hFF;
      ovf_clr      = 1'b1;
      tick();
      check("ovf_set_wins", 32'(ovf), 32'd1);
      bus.px_valid = 1'b0;
      tick();
      check("ovf_clear", 32'(ovf), 32'd0);
      ovf_clr = 1'b0;
`endif
      check("ovf_level_final", 32'(level), 32'd4);

      // Buffered 1..4 plus 5..8 form the first frame.
      bus.ready_out = 1'b1;
      start_frame();
      for (int i = 5; i <= 8; i++) push_when_room(PIX_W'(i));
      wait_frame_end(200);
      check("frame1_count", 32'(frames_done), 32'd1);
      check("frame1_level", 32'(level), 32'd0);

      // Latency and stall.
      bus.ready_out = 1'b0;
      start_frame();
      write_px(8'hA5);
      tick();
      bus.px_valid = 1'b0;
      check("lat_edge_n", 32'(bus.valid_out), 32'd0);
      tick();
      check("lat_edge_n1", 32'(bus.valid_out), 32'd1);
      check("lat_px", 32'(bus.px_out), 32'hA5);
      check("lat_sof", 32'(bus.sof), 32'd1);
      tick();
      tick();
      check("stall_px", 32'(bus.px_out), 32'hA5);
      bus.ready_out = 1'b1;
      tick();
      run_frame(500);
      check("frame2_count", 32'(frames_done), 32'd2);

      // Abort in idle drops leftovers.
      abort = 1'b1;
      tick();
      abort = 1'b0;
      exp_q.delete();
      check("abort_idle_level", 32'(level), 32'd0);

      // Abort after three pixels out, with start and a write in the same cycle.
      bus.ready_out = 1'b1;
      start_frame();
      written = 0;
      c = 0;
      while (pos < 3 && c < 300) begin
         bus.px_valid = 1'b0;
         if (written < FRAME && exp_q.size() < DEPTH) begin
            write_px(PIX_W'(8'h40 + written));
            written++;
         end
         tick();
         c++;
      end
      check("abort_pos", 32'(pos), 32'd3);
      abort         = 1'b1;
      start         = 1'b1;
      bus.ready_out = 1'b0;
      bus.px_valid  = 1'b1;
      bus.px_in     = 8'hEE;
      tick();
      abort        = 1'b0;
      start        = 1'b0;
      bus.px_valid = 1'b0;
      exp_q.delete();
      pos      = 0;
      in_frame = 1'b0;
      check("abort_level", 32'(level), 32'd0);
      check("abort_valid", 32'(bus.valid_out), 32'd0);
      bus.ready_out = 1'b1;
      write_px(8'h50);
      tick();
      bus.px_valid = 1'b0;
      repeat (3) tick();
      check("abort_idle_hold", 32'(level), 32'd1);
      start_frame();
      for (int i = 1; i < FRAME; i++) push_when_room(PIX_W'(8'h50 + i));
      wait_frame_end(200);
      check("frame3_count", 32'(frames_done), 32'd3);

      // Random frames with stray start pulses inside RUN.
      for (int f = 0; f < 6; f++) begin
         start_frame();
         run_frame(500);
      end
      check("frames_total", 32'(frames_done), 32'd9);

      // Reset between edges mid-frame.
      bus.ready_out = 1'b0;
      start_frame();
      for (int i = 0; i < 3; i++) push_when_room(PIX_W'($urandom));
      c = 0;
      while (!bus.valid_out && c < 20) begin
         tick();
         c++;
      end
      check("rst_pre_valid", 32'(bus.valid_out), 32'd1);
      @(posedge clk);
      #2;
      rst      = 1'b1;
      in_frame = 1'b0;
      #1;
      check("arst_valid", 32'(bus.valid_out), 32'd0);
      check("arst_px_out", 32'(bus.px_out), 32'd0);
      check("arst_level", 32'(level), 32'd0);
      check("arst_px_ready", 32'(bus.px_ready), 32'd1);
      check("arst_markers", 32'({bus.sof, bus.eol, bus.eof}), 32'd0);
      exp_q.delete();
      pos = 0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      tick();
      check("post_rst_level", 32'(level), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
